axi_posit_adder_regs: RTL
=========================

AXI_POSIT_ADDER_REGS -- requirements
Module: axi_posit_adder_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; 4 words decoded from addr[3:2].
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
- s00_axi_aclk  in  1  sole clock; all logic on rising edge.
- s00_axi_areset  in  1  synchronous active-high reset.
- s00_axi_awaddr  in  ADDR  write address.
- s00_axi_awvalid  in  1  write address valid.
- s00_axi_awready  out  1  write address ready.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte strobes.
- s00_axi_wvalid  in  1  write data valid.
- s00_axi_wready  out  1  write data ready.
- s00_axi_bresp  out  2  write response, always OKAY.
- s00_axi_bvalid  out  1  write response valid.
- s00_axi_bready  in  1  write response ready.
- s00_axi_araddr  in  ADDR  read address.
- s00_axi_arvalid  in  1  read address valid.
- s00_axi_arready  out  1  read address ready.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response, always OKAY.
- s00_axi_rvalid  out  1  read data valid.
- s00_axi_rready  in  1  read data ready.
- op_a  out  32  posit operand A to adder core.
- op_b  out  32  posit operand B to adder core.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  adder core accepts operands.
- res_data  in  32  posit sum from core.
- res_valid  in  1  single-cycle result strobe from core.

Function
REQ-004 SHALL provide the register map: 0x0 OPA (RW); 0x4 OPB (RW); 0x8 CTRL (bit0 START write-1, reads 0; bit1 BUSY RO; bit2 DONE, sticky, write-1-clear); 0xC RESULT (RO, writes ignored).
REQ-005 SHALL accept a write only when AW and W are both valid; awready and wready SHALL pulse high together for one cycle; bvalid SHALL rise the next cycle and hold until bready.
REQ-006 SHALL accept no new write while bvalid=1 and no new read while rvalid=1.
REQ-007 SHALL apply wstrb per byte to OPA and OPB.
REQ-008 SHALL pulse arready for one cycle on arvalid; rvalid SHALL rise the next cycle with rdata, and rdata SHALL hold until rready.
REQ-009 SHALL use an FSM IDLE -> ISSUE -> WAIT -> IDLE; a START write in IDLE SHALL enter ISSUE the next cycle.
REQ-010 SHALL drive op_valid=1 in ISSUE with op_a/op_b captured at START; the FSM SHALL go to WAIT on op_valid&op_ready.
REQ-011 In WAIT, res_valid SHALL load RESULT, set DONE and return to IDLE in the same edge.
REQ-012 SHALL ignore a START while BUSY, meaning state != IDLE.
REQ-013 SHALL ignore res_valid outside WAIT.
REQ-014 SHALL give START priority for DONE when START and a DONE clear hit the same cycle: DONE clears, and a new operation begins.
REQ-015 SHALL give set priority when the DONE set from res_valid coincides with a DONE W1C: DONE ends at 1.
REQ-016 SHALL leave in-flight operands unchanged when OPA or OPB is written during ISSUE or WAIT; the new values apply to the next START.

Reset
REQ-017 On reset, all outputs, registers and DONE SHALL be 0 and the FSM SHALL be IDLE; reset mid-operation SHALL abort the operation and drop op_valid the next cycle.

Verification
REQ-018 The bench SHALL write OPA=0x40000000 and OPB=0x40000000, write CTRL=1, then let the core respond -> RESULT=0x48000000 and CTRL reads 0x4.
REQ-019 The bench SHALL write OPA=0x12345678 with wstrb=0b0011 over prior 0xFFFFFFFF -> OPA reads 0xFFFF5678.
REQ-020 The bench SHALL hold op_ready=0 for 10 cycles after START -> op_valid stays 1, CTRL reads 0x2, and a second START is ignored.
REQ-021 The bench SHALL hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and rdata are held; no second transaction is accepted.
REQ-022 The bench SHALL write CTRL=0x5 while DONE=1 -> DONE clears and a new operation starts; then pulse reset in WAIT -> all zero and res_valid is ignored.

Source files
------------

// File: rtl/axi_posit_adder_regs.sv
// rtl/axi_posit_adder_regs.sv - AXI-Lite register front end for a posit adder core
//
// Purpose: exposes two posit operands, a control/status word and the result of
// an external adder core through a four-word AXI-Lite slave, and sequences one
// add per START through an IDLE -> ISSUE -> WAIT handshake with the core.
//
// Ports:
//   s00_axi_aclk / s00_axi_areset   clock, synchronous active-high reset
//   s00_axi_aw* / w* / b*           AXI-Lite write address, data, response
//   s00_axi_ar* / r*                AXI-Lite read address and data
//   op_a, op_b, op_valid, op_ready  operand handshake towards the adder core
//   res_data, res_valid             single-cycle result strobe from the core
//
// Register map (addr[3:2]):
//   0 OPA    RW, byte strobes honoured
//   1 OPB    RW, byte strobes honoured
//   2 CTRL   bit0 START (W1, reads 0), bit1 BUSY (RO), bit2 DONE (sticky, W1C)
//   3 RESULT RO

module axi_posit_adder_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [31:0]                     op_a,
  output logic [31:0]                     op_b,
  output logic                            op_valid,
  input  logic                            op_ready,
  input  logic [31:0]                     res_data,
  input  logic                            res_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] IDX_OPA    = 2'd0;
  localparam logic [1:0] IDX_OPB    = 2'd1;
  localparam logic [1:0] IDX_CTRL   = 2'd2;
  localparam logic [1:0] IDX_RESULT = 2'd3;

  state_t      state_q, state_d;

  logic        awready_q;
  logic        bvalid_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic        wr_en;
  logic        rd_en;
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;
  logic        ctrl_wr;
  logic        start;
  logic        done_w1c;
  logic        res_take;
  logic        busy;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  // Only addr[3:2] select a word; the remaining address bits are don't-care.
  assign unused_addr_bits = ^{s00_axi_awaddr, s00_axi_araddr};

  assign wr_idx   = s00_axi_awaddr[3:2];
  assign rd_idx   = s00_axi_araddr[3:2];

  // awready/wready are one registered pulse, so the write lands on the edge
  // that completes both handshakes while the master still holds AW and W.
  assign wr_en    = awready_q & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_en    = arready_q & s00_axi_arvalid;

  assign busy     = (state_q != S_IDLE);
  assign ctrl_wr  = wr_en && (wr_idx == IDX_CTRL);
  assign start    = ctrl_wr && s00_axi_wdata[0] && !busy;
  assign done_w1c = ctrl_wr && s00_axi_wdata[2];
  assign res_take = (state_q == S_WAIT) && res_valid;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) m[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return m;
  endfunction

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_ISSUE;
      S_ISSUE: if (op_ready)  state_d = S_WAIT;
      S_WAIT:  if (res_valid) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Register file next state
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    done_d   = done_q;

    if (wr_en && (wr_idx == IDX_OPA)) opa_d = merge_strb(opa_q, s00_axi_wdata[31:0], s00_axi_wstrb[3:0]);
    if (wr_en && (wr_idx == IDX_OPB)) opb_d = merge_strb(opb_q, s00_axi_wdata[31:0], s00_axi_wstrb[3:0]);

    // Operands are snapshotted at START so later OPA/OPB writes only affect
    // the next operation.
    if (start) begin
      op_a_d = opa_q;
      op_b_d = opb_q;
    end

    if (res_take) result_d = res_data;

    // START wins over everything (a fresh operation has no result yet);
    // a core completion wins over a coincident W1C so a result is never lost.
    if (start)         done_d = 1'b0;
    else if (res_take) done_d = 1'b1;
    else if (done_w1c) done_d = 1'b0;
  end

  // Read data selection
  always_comb begin
    rd_mux = 32'h0;
    case (rd_idx)
      IDX_OPA:    rd_mux = opa_q;
      IDX_OPB:    rd_mux = opb_q;
      IDX_CTRL:   rd_mux = {29'h0, done_q, busy, 1'b0};
      IDX_RESULT: rd_mux = result_q;
      default:    rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      opa_q     <= 32'h0;
      opb_q     <= 32'h0;
      op_a_q    <= 32'h0;
      op_b_q    <= 32'h0;
      result_q  <= 32'h0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      done_q   <= done_d;

      // No new write is offered while a response is still pending.
      awready_q <= !awready_q && !bvalid_q && s00_axi_awvalid && s00_axi_wvalid;
      if (wr_en)               bvalid_q <= 1'b1;
      else if (s00_axi_bready) bvalid_q <= 1'b0;

      // No new read is offered while read data is still pending; rdata is
      // captured once and held until the master takes it.
      arready_q <= !arready_q && !rvalid_q && s00_axi_arvalid;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = awready_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rdata   = {{(C_S_AXI_DATA_WIDTH-32){1'b0}}, rdata_q};
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rvalid  = rvalid_q;

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_valid = (state_q == S_ISSUE);

endmodule
